fifo_drain_framer: RTL and testbench
====================================

// Module: fifo_drain_framer
// PURPOSE
//  - Read-side consumer of sync_fifo: drains it via w/r_en-style pop (fifo_r_en/fifo_rd_data/fifo_empty)
//    and re-presents words as a valid/ready stream framed into fixed-length packets (out_last).
//  - Absorbs the FIFO's 1-cycle registered read latency with a 2-entry credit-controlled buffer;
//    sustains 1 word/cycle when the FIFO is non-empty and out_ready=1.
// PARAMETERS
//  - DATA_WIDTH   8   width of FIFO word and out_data
//  - PKT_LEN      4   beats per packet; legal range 1..65535
//  - FRAME_CNT_W  16  width of frame_cnt (completed-packet counter)
// PORTS
//  - clk          in   1           clock, rising edge
//  - rst_         in   1           reset, asynchronous assert, active-low
//  - enable       in   1           1 = issue new FIFO reads; 0 = stop reading, buffered words still drain
//  - fifo_empty   in   1           sync_fifo empty
//  - fifo_rd_data in   DATA_WIDTH  sync_fifo rd_data, valid the cycle after a pop
//  - fifo_r_en    out  1           pop request to sync_fifo
//  - out_valid    out  1           out_data/out_last valid
//  - out_ready    in   1           downstream accepts when out_valid&&out_ready (a "beat")
//  - out_data     out  DATA_WIDTH  oldest buffered word
//  - out_last     out  1           beat is final beat of a packet
//  - frame_cnt    out  FRAME_CNT_W packets completed since reset, wraps
//  - out_par      out  1           only with FIFO_DRAIN_PARITY_EN, see CONFIGURATION
// BEHAVIOUR
//  - Reset (rst_=0, async): buffer emptied, inflight=0, beat_cnt=0, frame_cnt=0; fifo_r_en=0, out_valid=0,
//    out_data=0, out_last=0; out_par=0 if present. Outputs stay at these values while rst_=0.
//  - inflight: 1-bit reg, set the cycle after fifo_r_en=1, i.e. fifo_rd_data is captured into buffer tail on
//    the edge ending the cycle after the pop. occ = buffer occupancy 0..2.
//  - fifo_r_en = enable && !fifo_empty && ((occ+inflight) < 2 || ((occ+inflight)==2 && beat)); never
//    overflows the buffer; combinational from out_ready by design.
//  - Latency: fifo_r_en in cycle N -> out_valid=1 in cycle N+2 (when buffer was empty).
//  - out_valid = (occ != 0); out_data = head entry; order strictly preserved; no drop, no duplication.
//  - Simultaneous capture + beat with occ=2: legal, occ stays 2; capture with occ=2 and no beat cannot occur.
//  - out_ready=0: buffer fills to 2, fifo_r_en held 0; out_valid/out_data held stable until beat.
//  - beat_cnt: 0..PKT_LEN-1, +1 per beat, wraps to 0 after PKT_LEN-1; out_last = out_valid &&
//    beat_cnt==PKT_LEN-1; PKT_LEN=1 -> out_last=1 on every valid beat.
//  - frame_cnt +1 on each beat with out_last=1; wraps 2^FRAME_CNT_W-1 -> 0.
//  - enable deassert mid-packet: no new pops from next cycle; in-flight word still captured; beat_cnt held.
//  - Reset mid-packet: partial packet discarded (beat_cnt=0); a word popped but not yet captured is lost.
//  - No FSM beyond counters; no state depends on fifo_full.
// CONFIGURATION
//  - FIFO_DRAIN_PARITY_EN defined: out_par port exists; out_par = ^out_data (even parity), registered
//    alongside buffer entries, valid whenever out_valid=1.
//  - Undefined: out_par port and parity storage absent; all other behaviour identical.
// STRUCTURE
//  - fifo_drain_pkg: localparam DRAIN_BUF_DEPTH=2; typedef struct packed {data; par} drain_entry_t
//    (par field only under macro); beat/frame counter width helper function.
//  - Sub-module drain_skid_buf: 2-entry buffer, push/pop/occ, head output; top holds credit,
//    beat and frame logic.
// TESTING
//  - Reset: rst_=0 mid-run -> all outputs 0 same cycle (async), beat_cnt/frame_cnt=0 after release.
//  - Streaming: FIFO preloaded 0x01..0x08, out_ready=1, enable=1, PKT_LEN=4 -> 8 beats on 8
//    consecutive cycles, data 0x01..0x08, out_last on 0x04 and 0x08, frame_cnt=2.
//  - Backpressure: out_ready=0 for 10 cycles with FIFO holding 5 -> exactly 2 pops, out_data=first word
//    stable; release -> remaining 5 words in order, no loss.
//  - Random out_ready (50%) and random enable, 1000 words -> scoreboard exact order, no overflow.
//  - PKT_LEN=1 -> out_last on every beat; frame_cnt equals beat count; FRAME_CNT_W=2 wraps 3->0.
//  - Parity build: data 0x07 -> out_par=1, 0x03 -> out_par=0; non-macro build compiles without out_par.

Source files
------------

// File: rtl/fifo_drain_pkg.sv
// rtl/fifo_drain_pkg.sv - shared constants, entry layout and width helpers for the FIFO drain framer
// Optional feature macro: FIFO_DRAIN_PARITY_EN (adds a parity bit to every buffered entry)
package fifo_drain_pkg;

    localparam int DRAIN_BUF_DEPTH = 2;
    localparam int DRAIN_DATA_W    = 8;

`ifdef FIFO_DRAIN_PARITY_EN
    localparam int DRAIN_PAR_W = 1;
    typedef struct packed {
        logic [DRAIN_DATA_W-1:0] data;
        logic                    par;
    } drain_entry_t;
`else
    localparam int DRAIN_PAR_W = 0;
    typedef struct packed {
        logic [DRAIN_DATA_W-1:0] data;
    } drain_entry_t;
`endif

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/drain_skid_buf.sv
// rtl/drain_skid_buf.sv - two-entry in-order buffer with push/pop, occupancy and head output
// Optional feature macro: FIFO_DRAIN_PARITY_EN (only widens the entry, no logic here depends on it)
module drain_skid_buf
    import fifo_drain_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   occ,
    output logic [W-1:0] head
);

    logic [W-1:0] mem0;
    logic [W-1:0] mem1;
    logic [1:0]   occ_r;

    // mem0 is always the head; a pop shifts mem1 forward so order is preserved.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            mem0  <= '0;
            mem1  <= '0;
            occ_r <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ_r == 2'd0) mem0 <= push_data;
                    else               mem1 <= push_data;
                    occ_r <= occ_r + 2'd1;
                end
                2'b01: begin
                    mem0  <= mem1;
                    occ_r <= occ_r - 2'd1;
                end
                2'b11: begin
                    if (occ_r == 2'd1) begin
                        mem0 <= push_data;
                    end else begin
                        mem0 <= mem1;
                        mem1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign occ  = occ_r;
    assign head = mem0;

    logic unused_depth;
    assign unused_depth = (DRAIN_BUF_DEPTH == 2);

endmodule

// File: rtl/fifo_drain_framer.sv
// rtl/fifo_drain_framer.sv - drains a sync FIFO into a valid/ready stream framed into PKT_LEN-beat packets
// Optional feature macro: FIFO_DRAIN_PARITY_EN (adds out_par, even parity of out_data)
module fifo_drain_framer
    import fifo_drain_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int PKT_LEN     = 4,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic                   enable,
    input  logic                   fifo_empty,
    input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
    output logic                   fifo_r_en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_last,
    output logic [FRAME_CNT_W-1:0] frame_cnt
`ifdef FIFO_DRAIN_PARITY_EN
    ,
    output logic                   out_par
`endif
);

    localparam int BEAT_W  = cnt_width(PKT_LEN);
    localparam int ENTRY_W = DATA_WIDTH + DRAIN_PAR_W;

`ifdef FIFO_DRAIN_PARITY_EN
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  par;
    } entry_t;
`else
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
    } entry_t;
`endif

    logic              inflight;
    logic [1:0]        occ;
    logic [2:0]        credit;
    logic              beat;
    logic              at_last;
    logic [BEAT_W-1:0] beat_cnt;
    entry_t            push_entry;
    entry_t            head_entry;
    logic [ENTRY_W-1:0] head_bits;

    always_comb begin
        push_entry      = '0;
        push_entry.data = fifo_rd_data;
`ifdef FIFO_DRAIN_PARITY_EN
        push_entry.par  = ^fifo_rd_data;
`endif
    end

    drain_skid_buf #(
        .W (ENTRY_W)
    ) u_buf (
        .clk       (clk),
        .rst_      (rst_),
        .push      (inflight),
        .push_data (push_entry),
        .pop       (beat),
        .occ       (occ),
        .head      (head_bits)
    );

    assign head_entry = head_bits;

    // Credits count both buffered words and the one still travelling out of the FIFO;
    // a same-cycle beat frees a slot, which lets a full buffer keep 1 word/cycle.
    assign credit    = {1'b0, occ} + {2'b00, inflight};
    assign fifo_r_en = rst_ && enable && !fifo_empty &&
                       ((credit < 3'(DRAIN_BUF_DEPTH)) ||
                        ((credit == 3'(DRAIN_BUF_DEPTH)) && beat));

    assign out_valid = (occ != 2'd0);
    assign out_data  = head_entry.data;
    assign at_last   = (beat_cnt == BEAT_W'(PKT_LEN - 1));
    assign out_last  = out_valid && at_last;
    assign beat      = out_valid && out_ready;

`ifdef FIFO_DRAIN_PARITY_EN
    assign out_par = head_entry.par;
`endif

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            inflight  <= 1'b0;
            beat_cnt  <= '0;
            frame_cnt <= '0;
        end else begin
            inflight <= fifo_r_en;
            if (beat) begin
                beat_cnt <= at_last ? '0 : beat_cnt + 1'b1;
                if (at_last) frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_drain_framer.sv
// tb/tb_fifo_drain_framer.sv - scoreboard bench for fifo_drain_framer with a registered-read FIFO model
module tb_fifo_drain_framer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_;
    logic        enable;
    logic        out_ready;
    logic        fifo_empty;
    logic [7:0]  fifo_rd_data = 8'h00;
    logic        fifo_r_en;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic [15:0] frame_cnt;

    logic        en1;
    logic        empty1 = 1'b0;
    logic [7:0]  rd_data1 = 8'h5A;
    logic        ready1 = 1'b1;
    logic        r_en1;
    logic        valid1;
    logic [7:0]  data1;
    logic        last1;
    logic [1:0]  frame_cnt1;

`ifdef FIFO_DRAIN_PARITY_EN
    logic        out_par;
    logic        out_par1;
`endif

    fifo_drain_framer #(.DATA_WIDTH(8), .PKT_LEN(4), .FRAME_CNT_W(16)) dut (
        .clk          (clk),
        .rst_         (rst_),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_r_en    (fifo_r_en),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .frame_cnt    (frame_cnt)
`ifdef FIFO_DRAIN_PARITY_EN
        ,
        .out_par      (out_par)
`endif
    );

    fifo_drain_framer #(.DATA_WIDTH(8), .PKT_LEN(1), .FRAME_CNT_W(2)) dut1 (
        .clk          (clk),
        .rst_         (rst_),
        .enable       (en1),
        .fifo_empty   (empty1),
        .fifo_rd_data (rd_data1),
        .fifo_r_en    (r_en1),
        .out_valid    (valid1),
        .out_ready    (ready1),
        .out_data     (data1),
        .out_last     (last1),
        .frame_cnt    (frame_cnt1)
`ifdef FIFO_DRAIN_PARITY_EN
        ,
        .out_par      (out_par1)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    // Registered-read FIFO model: data appears the cycle after a pop.
    logic [7:0] fmem [0:2047];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_r_en) begin
            fifo_rd_data <= fmem[rd_ptr[10:0]];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    typedef struct {
        logic [7:0] d;
        logic       l;
    } exp_t;
    exp_t exp_q[$];
    int   exp_idx = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int mon_beats  = 0;
    int mon_frames = 0;
    int beat_cyc [0:2047];

    always @(negedge clk) begin
        if (!rst_) begin
            mon_frames = 0;
        end else if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL spurious_beat: got data %0h with empty scoreboard", out_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("beat_data", out_data, e.d);
                check("beat_last", out_last, e.l);
                check("beat_frame_cnt", frame_cnt, mon_frames[15:0]);
`ifdef FIFO_DRAIN_PARITY_EN
                check("beat_par", out_par, ^e.d);
`endif
                if (e.l) mon_frames++;
                beat_cyc[mon_beats[10:0]] = cyc;
                mon_beats++;
            end
        end
    end

    int b1 = 0;
    always @(negedge clk) begin
        if (rst_ && valid1 && ready1) begin
            check("pkt1_last", last1, 1);
            check("pkt1_frame_cnt", frame_cnt1, b1[1:0]);
            b1++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] d, input bit track);
        fmem[wr_ptr[10:0]] = d;
        wr_ptr++;
        if (track) begin
            exp_q.push_back('{d, (exp_idx % 4) == 3});
            exp_idx++;
        end
    endtask

    task automatic wait_drain(input string name, input int max);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || out_valid || !fifo_empty) && k < max) begin
            step();
            k++;
        end
        check(name, (k < max), 1);
    endtask

    initial begin
        int b0;
        int c0;
        int start;
        int pushed;

        rst_ = 1'b0; enable = 1'b0; out_ready = 1'b0; en1 = 1'b0;
        repeat (3) step();
        check("rst_out_valid", out_valid, 0);
        check("rst_fifo_r_en", fifo_r_en, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        rst_ = 1'b1;
        step();

        en1 = 1'b1;
        repeat (6) step();
        en1 = 1'b0;
        repeat (4) step();
        check("pkt1_beats", b1, 6);
        check("pkt1_wrap", frame_cnt1, 2);

        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push_word(8'(i), 1'b1);
        step();
        check("disabled_no_pop", fifo_r_en, 0);
        b0 = mon_beats;
        c0 = cyc;
        enable = 1'b1;
        wait_drain("stream_drain", 50);
        check("stream_latency", beat_cyc[b0[10:0]] - c0, 2);
        check("stream_span", beat_cyc[(b0 + 7) & 2047] - beat_cyc[b0[10:0]], 7);
        check("stream_frames", frame_cnt, 2);

        out_ready = 1'b0;
        start = rd_ptr;
        for (int i = 0; i < 5; i++) push_word(8'h10 + 8'(i), 1'b1);
        repeat (10) step();
        check("bp_pops", rd_ptr - start, 2);
        check("bp_valid", out_valid, 1);
        check("bp_head", out_data, 8'h10);
        check("bp_r_en", fifo_r_en, 0);
        out_ready = 1'b1;
        wait_drain("bp_drain", 50);
        check("bp_frames", frame_cnt, 3);

        pushed = 0;
        while (pushed < 1000) begin
            enable    = ($urandom % 4) != 0;
            out_ready = ($urandom % 2) != 0;
            if (($urandom % 2) != 0) begin
                push_word(8'($urandom), 1'b1);
                pushed++;
            end
            step();
        end
        enable    = 1'b1;
        out_ready = 1'b1;
        wait_drain("rand_drain", 3000);
        check("rand_frames", frame_cnt, 253);

        out_ready = 1'b0;
        push_word(8'hAA, 1'b0);
        push_word(8'hBB, 1'b0);
        repeat (4) step();
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_head", out_data, 8'hAA);
        #2;
        rst_ = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_data", out_data, 0);
        check("async_rst_last", out_last, 0);
        check("async_rst_r_en", fifo_r_en, 0);
        step();
        step();
        rst_ = 1'b1;
        check("post_rst_frames", frame_cnt, 0);
        exp_idx   = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_word(8'h21 + 8'(i), 1'b1);
        wait_drain("post_rst_drain", 50);
        check("post_rst_frame_done", frame_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
